// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data port, packs store lanes, extends load data.
// Latency: misaligned 1 cycle, store >= 2, load >= 3; stall holds the pipeline while an access is in flight.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        exc_misalign,
    output logic        exc_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      ld_q, ld_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic             bus_q, bus_d;

    logic        is_half, is_word, misalign, wd_expire;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] ext_c;

    // size 3 falls into the word case through op_size[1]
    assign is_half  = (op_size == 2'd1);
    assign is_word  = op_size[1];
    assign misalign = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));
    assign wd_expire = (TIMEOUT != 0) && (cnt_q == WD_LAST);

    always_comb begin
        be_c    = 4'b0001 << op_addr[1:0];
        wdata_c = {4{op_wdata[7:0]}};
        if (is_word) begin
            be_c    = 4'b1111;
            wdata_c = op_wdata;
        end else if (is_half) begin
            be_c    = op_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{op_wdata[15:0]}};
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    rb = mem_rdata[7:0];
            2'd1:    rb = mem_rdata[15:8];
            2'd2:    rb = mem_rdata[23:16];
            default: rb = mem_rdata[31:24];
        endcase
        rh = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (size_q[1])
            ext_c = mem_rdata;
        else if (size_q == 2'd1)
            ext_c = {(uns_q ? 16'h0000 : {16{rh[15]}}), rh};
        else
            ext_c = {(uns_q ? 24'h000000 : {24{rb[7]}}), rb};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        mis_d   = 1'b0;
        bus_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (misalign) begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        addr_d  = {op_addr[31:2], 2'b00};
                        we_d    = op_store;
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        size_d  = op_size;
                        uns_d   = op_unsigned;
                        lane_d  = op_addr[1:0];
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // a grant in the expiry cycle still completes the access
                if (mem_gnt) begin
                    state_d = we_q ? S_DONE : S_RESP;
                end else if (wd_expire) begin
                    state_d = S_DONE;
                    bus_d   = 1'b1;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d = S_DONE;
                    ld_d    = ext_c;
                end else if (wd_expire) begin
                    state_d = S_DONE;
                    bus_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            lane_q  <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ld_q    <= 32'h0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
        end
    end

    assign stall        = ((state_q == S_IDLE) && op_valid) || (state_q == S_REQ) || (state_q == S_RESP);
    assign done         = done_q;
    assign ld_data      = ld_q;
    assign exc_misalign = mis_q;
    assign exc_bus      = bus_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

endmodule
